pipe_stall_flush_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Arbitrates stall/flush requests (load-use hazard,
//  EX redirect, multi-cycle EX op, I/D memory wait) and drives per-stage register enables and flushes.

---
 rtl/pipe_stall_flush_ctrl_if.sv | 35 +++
 rtl/pipe_stall_flush_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_stall_flush_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_flush_ctrl_if.sv
// Bundles the hazard/stall request inputs and the per-stage enable/flush outputs
// of the pipeline sequencer.
interface pipe_stall_flush_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ld_use_stall;
    logic                 ex_redirect;
    logic                 mc_start;
    logic                 mc_done;
    logic                 dmem_wait;
    logic                 imem_wait;
    logic                 ctrl_clr;
    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_mem_en;
    logic                 mem_wb_en;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 ex_mem_flush;
    logic [1:0]           ctrl_state;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic                 timeout_err;

    modport master (
        output ld_use_stall, ex_redirect, mc_start, mc_done, dmem_wait, imem_wait, ctrl_clr,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state, stall_cycles, timeout_err
    );
    modport slave (
        input  ld_use_stall, ex_redirect, mc_start, mc_done, dmem_wait, imem_wait, ctrl_clr,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state, stall_cycles, timeout_err
    );
endinterface

// File: rtl/pipe_stall_flush_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: prioritised per-stage enables and
// flushes, a RUN/MC_WAIT/REDIRECT FSM, a saturating stall counter and a freeze watchdog.
module pipe_stall_flush_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16,
    parameter int WDT_LIMIT    = 255
) (
    input  logic                    pipe_ctrl_clk,
    input  logic                    pipe_ctrl_rst,
    pipe_stall_flush_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'b00, MC_WAIT = 2'b01, REDIRECT = 2'b10} state_t;

    localparam logic [3:0] FC      = 4'(FLUSH_CYCLES);
    localparam int         WDT_W   = $clog2(WDT_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

    state_t               r_state, w_nxt;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_stall;
    logic [WDT_W-1:0]     r_wdt;
    logic                 r_to;
    logic                 w_freeze, w_frozen;
    logic [7:0]           w_ctl;   // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem flush}

    assign w_freeze = ((r_state == MC_WAIT) && !bus.mc_done) ||
                      ((r_state == RUN) && bus.mc_start && !bus.mc_done);
    assign w_frozen = bus.dmem_wait || w_freeze;

    always_comb begin
        w_ctl = 8'b11111_000;
        if (!pipe_ctrl_rst)             w_ctl = 8'b00000_000;
        else if (bus.dmem_wait)         w_ctl = 8'b00000_000;
        else if (w_freeze)              w_ctl = 8'b00001_001;
        else if (bus.ex_redirect)       w_ctl = 8'b11111_110;
        else if (r_state == REDIRECT)   w_ctl = 8'b11111_100;
        else if (bus.ld_use_stall)      w_ctl = 8'b00111_010;
        else if (bus.imem_wait)         w_ctl = 8'b01111_100;
    end

    assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush} = w_ctl;
    assign bus.ctrl_state   = r_state;
    assign bus.stall_cycles = r_stall;
    assign bus.timeout_err  = r_to;

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        if (!bus.dmem_wait) begin
            case (r_state)
                RUN: begin
                    if (bus.mc_start && !bus.mc_done) begin
                        w_nxt = MC_WAIT;
                    end else if (bus.ex_redirect && (FC != 4'd0)) begin
                        w_nxt     = REDIRECT;
                        w_cnt_nxt = FC;
                    end
                end
                MC_WAIT: if (bus.mc_done) w_nxt = RUN;
                REDIRECT: begin
                    if (bus.ex_redirect) begin
                        w_cnt_nxt = FC;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                        if (r_cnt == 4'd1) w_nxt = RUN;
                    end
                end
                default: begin
                    w_nxt     = RUN;
                    w_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge pipe_ctrl_clk or negedge pipe_ctrl_rst) begin
        if (!pipe_ctrl_rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Watchdog saturates at the limit so a long freeze never wraps back below it.
    always_ff @(posedge pipe_ctrl_clk or negedge pipe_ctrl_rst) begin
        if (!pipe_ctrl_rst) begin
            r_stall <= '0;
            r_wdt   <= '0;
            r_to    <= 1'b0;
        end else if (bus.ctrl_clr) begin
            r_stall <= '0;
            r_wdt   <= '0;
            r_to    <= 1'b0;
        end else begin
            if (!bus.pc_en && (r_stall != {CNT_WIDTH{1'b1}})) r_stall <= r_stall + 1'b1;
            if (w_frozen) begin
                if (r_wdt != WDT_MAX)               r_wdt <= r_wdt + 1'b1;
                if (r_wdt == WDT_MAX - 1'b1)        r_to  <= 1'b1;
            end else begin
                r_wdt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Scoreboard bench: a behavioural model predicts each cycle's controls and counters,
// queues them when inputs are driven, and the queue is popped against the DUT at negedge.
module tb_pipe_stall_flush_ctrl;
    localparam int FLUSH = 1;
    localparam int CW    = 3;
    localparam int WDT   = 3;
    localparam int SMAX  = (1 << CW) - 1;

    typedef struct {
        logic [7:0]    ctl;
        logic [1:0]    st;
        logic [CW-1:0] stall;
        logic          to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    exp_t q[$];

    int m_state, m_cnt, m_stall, m_wdt;
    logic m_to;

    pipe_stall_flush_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    pipe_stall_flush_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_WIDTH(CW), .WDT_LIMIT(WDT)) dut (
        .pipe_ctrl_clk (clk),
        .pipe_ctrl_rst (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] act_ctl();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_stall = 0; m_wdt = 0; m_to = 1'b0;
    endtask

    // Predict this cycle's outputs from current model state, then advance the model past the edge.
    task automatic model_step(output exp_t e);
        bit frz, pc;
        frz = (m_state == 1 && !bus.mc_done) || (m_state == 0 && bus.mc_start && !bus.mc_done);
        e.st = 2'(m_state); e.stall = CW'(m_stall); e.to = m_to;
        if (bus.dmem_wait)          e.ctl = 8'b00000000;
        else if (frz)               e.ctl = 8'b00001001;
        else if (bus.ex_redirect)   e.ctl = 8'b11111110;
        else if (m_state == 2)      e.ctl = 8'b11111100;
        else if (bus.ld_use_stall)  e.ctl = 8'b00111010;
        else if (bus.imem_wait)     e.ctl = 8'b01111100;
        else                        e.ctl = 8'b11111000;
        pc = e.ctl[7];
        if (!bus.dmem_wait) begin
            if (m_state == 0) begin
                if (bus.mc_start && !bus.mc_done) m_state = 1;
                else if (bus.ex_redirect && FLUSH > 0) begin m_state = 2; m_cnt = FLUSH; end
            end else if (m_state == 1) begin
                if (bus.mc_done) m_state = 0;
            end else begin
                if (bus.ex_redirect) m_cnt = FLUSH;
                else begin m_cnt--; if (m_cnt == 0) m_state = 0; end
            end
        end
        if (bus.ctrl_clr) begin
            m_stall = 0; m_wdt = 0; m_to = 1'b0;
        end else begin
            if (!pc && m_stall < SMAX) m_stall++;
            if (bus.dmem_wait || frz) begin
                m_wdt++;
                if (m_wdt >= WDT) m_to = 1'b1;
            end else m_wdt = 0;
        end
    endtask

    // One cycle: inputs driven just after posedge, compared at negedge.
    // Input bit order: {ld_use, redirect, mc_start, mc_done, dmem, imem, clr}
    task automatic cyc(input logic [6:0] in);
        exp_t e, g;
        {bus.ld_use_stall, bus.ex_redirect, bus.mc_start, bus.mc_done,
         bus.dmem_wait, bus.imem_wait, bus.ctrl_clr} = in;
        model_step(e);
        q.push_back(e);
        @(negedge clk);
        g = q.pop_front();
        chk("ctl", 32'(act_ctl()), 32'(g.ctl));
        chk("state", 32'(bus.ctrl_state), 32'(g.st));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(g.stall));
        chk("timeout_err", 32'(bus.timeout_err), 32'(g.to));
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] IDLE = 7'b0000000, LDU = 7'b1000000, RDR = 7'b0100000,
                           MCS = 7'b0010000, MCD = 7'b0001000, DMW = 7'b0000100,
                           IMW = 7'b0000010, CLR = 7'b0000001;

    initial begin
        logic [6:0] r;
        {bus.ld_use_stall, bus.ex_redirect, bus.mc_start, bus.mc_done,
         bus.dmem_wait, bus.imem_wait, bus.ctrl_clr} = IDLE;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bus.imem_wait = 1'b1;
        #1;
        chk("rst_ctl", 32'(act_ctl()), 32'h0);
        chk("rst_state", 32'(bus.ctrl_state), 32'h0);
        chk("rst_stall", 32'(bus.stall_cycles), 32'h0);
        chk("rst_to", 32'(bus.timeout_err), 32'h0);
        bus.imem_wait = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        cyc(IDLE);
        cyc(LDU); cyc(IDLE);
        cyc(RDR); cyc(LDU); cyc(IDLE);
        cyc(IMW); cyc(IMW | LDU);
        cyc(CLR);
        cyc(MCS); repeat (3) cyc(IDLE); cyc(MCD); cyc(IDLE);
        cyc(CLR);
        cyc(MCS); cyc(DMW); cyc(DMW); cyc(IDLE); cyc(MCD); cyc(IDLE);
        cyc(CLR);
        cyc(MCS | MCD); cyc(MCD); cyc(IDLE);
        cyc(CLR);
        repeat (3) cyc(DMW); cyc(IDLE); cyc(IDLE); cyc(CLR); cyc(IDLE);
        cyc(DMW); cyc(DMW); cyc(DMW | CLR); cyc(IDLE);
        cyc(CLR);
        repeat (9) cyc(LDU); cyc(IDLE);
        cyc(RDR); cyc(RDR); cyc(DMW); cyc(IDLE); cyc(IDLE);
        cyc(RDR); cyc(RDR | DMW); cyc(IMW); cyc(IDLE);

        for (int i = 0; i < 300; i++) begin
            r = IDLE;
            r[6] = ($urandom_range(0, 3) == 0);
            r[5] = ($urandom_range(0, 7) == 0);
            r[4] = !r[5] && ($urandom_range(0, 9) == 0);
            r[3] = !r[5] && ($urandom_range(0, 4) == 0);
            r[2] = ($urandom_range(0, 5) == 0);
            r[1] = ($urandom_range(0, 4) == 0);
            r[0] = ($urandom_range(0, 19) == 0);
            cyc(r);
        end
        cyc(CLR | MCD);

        // Async reset while in REDIRECT
        cyc(RDR);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_state", 32'(bus.ctrl_state), 32'h0);
        chk("arst_ctl", 32'(act_ctl()), 32'h0);
        chk("arst_stall", 32'(bus.stall_cycles), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        {bus.ld_use_stall, bus.ex_redirect, bus.mc_start, bus.mc_done,
         bus.dmem_wait, bus.imem_wait, bus.ctrl_clr} = IDLE;
        cyc(LDU); cyc(IDLE);

        if (q.size() != 0) chk("queue_empty", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
